// File: rtl/alarm_bank_ctrl.sv
// Multi-slot alarm controller: N_ALARMS hh:mm slots, ring/snooze/dismiss FSM, 1 Hz buzzer.
// Optional snooze support is built when the SNOOZE_EN macro is defined.

module alarm_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_hr,
  input  logic [5:0] wr_min,
  input  logic       wr_on,
  input  logic       min_tick,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_min,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic       on,
  output logic       hit
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr  <= '0;
      min <= '0;
      on  <= 1'b0;
    end else if (wr_en) begin
      hr  <= wr_hr;
      min <= wr_min;
      on  <= wr_on;
    end
  end

  assign hit = min_tick && on && (hr == cur_hr) && (min == cur_min);

endmodule

module alarm_bank_ctrl #(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60,
  localparam int IDX_W     = $clog2(N_ALARMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sec_tick,
  input  logic                min_tick,
  input  logic [4:0]          cur_hr,
  input  logic [5:0]          cur_min,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [4:0]          wr_hr,
  input  logic [5:0]          wr_min,
  input  logic                wr_on,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [4:0]          rd_hr,
  output logic [5:0]          rd_min,
  input  logic                snooze,
  input  logic                dismiss,
  output logic [N_ALARMS-1:0] alarm_on,
  output logic                ringing,
  output logic                snoozed,
  output logic [IDX_W-1:0]    ring_idx,
  output logic                buzz
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RING = 2'd1;
`ifdef SNOOZE_EN
  localparam logic [1:0] ST_SNZ  = 2'd2;
`endif
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  logic [1:0]                state;
  logic [7:0]                ring_cnt;
  logic [N_ALARMS-1:0][4:0]  slot_hr;
  logic [N_ALARMS-1:0][5:0]  slot_min;
  logic [N_ALARMS-1:0]       slot_on;
  logic [N_ALARMS-1:0]       slot_hit;
  logic [N_ALARMS-1:0]       slot_wr;
  logic                      wr_ok;
  logic                      hit_any;
  logic [IDX_W-1:0]          hit_idx;
  logic                      slot_off;

  // Out-of-range time or slot index drops the whole write.
  assign wr_ok = wr_en && (wr_hr <= 5'd23) && (wr_min <= 6'd59) &&
                 (32'(wr_idx) < N_ALARMS);

  genvar g;
  generate
    for (g = 0; g < N_ALARMS; g++) begin : g_slot
      assign slot_wr[g] = wr_ok && (32'(wr_idx) == g);
      alarm_slot u_slot (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (slot_wr[g]),
        .wr_hr    (wr_hr),
        .wr_min   (wr_min),
        .wr_on    (wr_on),
        .min_tick (min_tick),
        .cur_hr   (cur_hr),
        .cur_min  (cur_min),
        .hr       (slot_hr[g]),
        .min      (slot_min[g]),
        .on       (slot_on[g]),
        .hit      (slot_hit[g])
      );
    end
  endgenerate

  assign alarm_on = slot_on;

  always_comb begin
    rd_hr  = '0;
    rd_min = '0;
    if (32'(rd_idx) < N_ALARMS) begin
      rd_hr  = slot_hr[rd_idx];
      rd_min = slot_min[rd_idx];
    end
  end

  // Lowest matching slot wins.
  always_comb begin
    hit_idx = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--)
      if (slot_hit[i]) hit_idx = IDX_W'(i);
  end
  assign hit_any = |slot_hit;

  // Active slot disabled now, or being disabled by this cycle's write.
  assign slot_off = !slot_on[ring_idx] ||
                    (wr_ok && (wr_idx == ring_idx) && !wr_on);

`ifdef SNOOZE_EN
  logic [4:0] snz_hr, nxt_hr;
  logic [5:0] snz_min, nxt_min;
  logic [6:0] snz_sum;

  always_comb begin
    snz_sum = {1'b0, cur_min} + 7'(SNOOZE_MIN);
    nxt_hr  = cur_hr;
    nxt_min = snz_sum[5:0];
    if (snz_sum >= 7'd60) begin
      nxt_min = 6'(snz_sum - 7'd60);
      nxt_hr  = (cur_hr == 5'd23) ? 5'd0 : cur_hr + 5'd1;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ring_idx <= '0;
      ring_cnt <= '0;
      buzz     <= 1'b0;
`ifdef SNOOZE_EN
      snz_hr   <= '0;
      snz_min  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit_any && !dismiss) begin
            state    <= ST_RING;
            ring_idx <= hit_idx;
            ring_cnt <= '0;
            buzz     <= 1'b1;
          end
        end
        ST_RING: begin
          if (dismiss || slot_off) begin
            state <= ST_IDLE;
            buzz  <= 1'b0;
          end
`ifdef SNOOZE_EN
          else if (snooze) begin
            state   <= ST_SNZ;
            buzz    <= 1'b0;
            snz_hr  <= nxt_hr;
            snz_min <= nxt_min;
          end
`endif
          else if (sec_tick) begin
            if (ring_cnt == RING_LAST) begin
              state <= ST_IDLE;
              buzz  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
              buzz     <= ~buzz;
            end
          end
        end
`ifdef SNOOZE_EN
        ST_SNZ: begin
          buzz <= 1'b0;
          if (dismiss || slot_off) begin
            state <= ST_IDLE;
          end else if (min_tick && (cur_hr == snz_hr) && (cur_min == snz_min)) begin
            state    <= ST_RING;
            ring_cnt <= '0;
            buzz     <= 1'b1;
          end else if (hit_any) begin
            // A fresh alarm supersedes the pending snooze.
            state    <= ST_RING;
            ring_idx <= hit_idx;
            ring_cnt <= '0;
            buzz     <= 1'b1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          buzz  <= 1'b0;
        end
      endcase
    end
  end

  assign ringing = (state == ST_RING);
`ifdef SNOOZE_EN
  assign snoozed = (state == ST_SNZ);
`else
  assign snoozed = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_bank_ctrl.sv
// Directed bench for alarm_bank_ctrl (N_ALARMS=4, SNOOZE_MIN=5, RING_SECS=60).
module tb_alarm_bank_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       sec_tick, min_tick, wr_en, wr_on, snooze, dismiss;
  logic [4:0] cur_hr, wr_hr, rd_hr;
  logic [5:0] cur_min, wr_min, rd_min;
  logic [1:0] wr_idx, rd_idx, ring_idx;
  logic [3:0] alarm_on;
  logic       ringing, snoozed, buzz;

  int n_chk = 0;
  int n_pass = 0;

  alarm_bank_ctrl #(.N_ALARMS(4), .SNOOZE_MIN(5), .RING_SECS(60)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .min_tick(min_tick),
    .cur_hr(cur_hr), .cur_min(cur_min), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_hr(wr_hr), .wr_min(wr_min), .wr_on(wr_on), .rd_idx(rd_idx),
    .rd_hr(rd_hr), .rd_min(rd_min), .snooze(snooze), .dismiss(dismiss),
    .alarm_on(alarm_on), .ringing(ringing), .snoozed(snoozed),
    .ring_idx(ring_idx), .buzz(buzz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [4:0] h, input logic [5:0] m, input logic on);
    wr_en = 1'b1; wr_idx = idx; wr_hr = h; wr_min = m; wr_on = on;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic mtick(input logic [4:0] h, input logic [5:0] m);
    cur_hr = h; cur_min = m; min_tick = 1'b1;
    tick();
    min_tick = 1'b0;
  endtask

  task automatic stick();
    sec_tick = 1'b1;
    tick();
    sec_tick = 1'b0;
  endtask

  task automatic pulse_dismiss();
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sec_tick = 0; min_tick = 0; wr_en = 0; wr_on = 0;
    snooze = 0; dismiss = 0; cur_hr = 0; cur_min = 0; wr_hr = 0; wr_min = 0;
    wr_idx = 0; rd_idx = 2;
    tick(); tick();
    check("rst_ringing", ringing, 0);
    check("rst_snoozed", snoozed, 0);
    check("rst_buzz", buzz, 0);
    check("rst_ring_idx", ring_idx, 0);
    check("rst_alarm_on", alarm_on, 4'b0000);
    check("rst_rd", {rd_hr, rd_min}, 0);
    rst = 1'b0;
    tick();

    // slot 2 = 07:30
    wr(2, 7, 30, 1);
    check("wr_alarm_on", alarm_on, 4'b0100);
    check("wr_rd_hr", rd_hr, 7);
    check("wr_rd_min", rd_min, 30);
    cur_hr = 7; cur_min = 30; tick();
    check("no_tick_no_ring", ringing, 0);
    mtick(7, 29);
    check("wrong_time_no_ring", ringing, 0);
    mtick(7, 30);
    check("t1_ringing", ringing, 1);
    check("t1_ring_idx", ring_idx, 2);
    check("t1_buzz_on", buzz, 1);
    stick();
    check("t1_buzz_tog0", buzz, 0);
    stick();
    check("t1_buzz_tog1", buzz, 1);
    pulse_dismiss();
    check("dismiss_ringing", ringing, 0);
    check("dismiss_buzz", buzz, 0);

    // out-of-range writes dropped
    wr(2, 24, 0, 1);
    check("bad_hr_rd", {rd_hr, rd_min}, {5'd7, 6'd30});
    wr(2, 6, 60, 0);
    check("bad_min_rd", {rd_hr, rd_min}, {5'd7, 6'd30});
    check("bad_min_on", alarm_on, 4'b0100);

    // slots 1 and 3 both 06:00 -> lowest wins
    wr(1, 6, 0, 1);
    wr(3, 6, 0, 1);
    check("t2_alarm_on", alarm_on, 4'b1110);
    mtick(6, 0);
    check("t2_ringing", ringing, 1);
    check("t2_ring_idx", ring_idx, 1);

    // snooze + dismiss together -> IDLE
    snooze = 1; dismiss = 1; tick(); snooze = 0; dismiss = 0;
    check("t6_both_ringing", ringing, 0);
    check("t6_both_snoozed", snoozed, 0);

    // timeout after 60 sec_ticks
    mtick(6, 0);
    check("t4_start", ringing, 1);
    for (int i = 0; i < 59; i++) stick();
    check("t4_59_ringing", ringing, 1);
    check("t4_59_buzz", buzz, 0);
    stick();
    check("t4_60_ringing", ringing, 0);
    check("t4_60_buzz", buzz, 0);

`ifdef SNOOZE_EN
    wr(0, 23, 58, 1);
    mtick(23, 58);
    check("t3_ring_idx", ring_idx, 0);
    snooze = 1; tick(); snooze = 0;
    check("t3_snoozed", snoozed, 1);
    check("t3_not_ringing", ringing, 0);
    check("t3_buzz_off", buzz, 0);
    mtick(0, 2);
    check("t3_early", snoozed, 1);
    mtick(0, 3);
    check("t3_reringing", ringing, 1);
    check("t3_same_idx", ring_idx, 0);
    pulse_dismiss();
`else
    mtick(6, 0);
    snooze = 1; tick(); snooze = 0;
    check("snz_ignored_ringing", ringing, 1);
    check("snz_ignored_snoozed", snoozed, 0);
    pulse_dismiss();
`endif

    // disabling the ringing slot ends the ring
    mtick(6, 0);
    check("t5_ring_idx", ring_idx, 1);
    wr(1, 6, 0, 0);
    check("t5_off_ringing", ringing, 0);
    check("t5_off_bit", alarm_on[1], 0);

    // slot 3 still matches; rst mid-ring clears everything at once
    mtick(6, 0);
    check("t6_ring_idx3", ring_idx, 3);
    rst = 1'b1;
    #2;
    check("t6_rst_ringing", ringing, 0);
    check("t6_rst_buzz", buzz, 0);
    check("t6_rst_idx", ring_idx, 0);
    check("t6_rst_on", alarm_on, 4'b0000);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
